// File: rtl/input_conditioner.sv
// input_conditioner: synchronises and debounces the calculator keys and
// switches, producing clean Enter/Clear pulses and a settled switch bus.
module input_conditioner_button #(
    parameter int DEBOUNCE_CYCLES   = 250000,
    parameter int CNT_W             = 18,
    parameter bit BUTTON_ACTIVE_LOW = 1'b1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic key,
    output logic press
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       sync;
    logic             pressed;

    assign pressed = sync[1] ^ BUTTON_ACTIVE_LOW;

    // Synchronisers come out of reset at the released level
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync  <= {2{BUTTON_ACTIVE_LOW}};
            state <= RELEASED;
            cnt   <= '0;
        end else begin
            sync  <= {sync[0], key};
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        press   = 1'b0;
        case (state)
            RELEASED: begin
                if (pressed) begin
                    state_n = PRESS_WAIT;
                    cnt_n   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!pressed) begin
                    state_n = RELEASED;
                end else if (cnt == LAST) begin
                    state_n = PRESSED;
                    press   = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!pressed) begin
                    state_n = RELEASE_WAIT;
                    cnt_n   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (pressed) begin
                    state_n = PRESSED;
                end else if (cnt == LAST) begin
                    state_n = RELEASED;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = RELEASED;
        endcase
    end
endmodule

module input_conditioner #(
    parameter int DEBOUNCE_CYCLES   = 250000,
    parameter int CNT_W             = 18,
    parameter bit BUTTON_ACTIVE_LOW = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        KeyEnter,
    input  logic        KeyClear,
    input  logic [11:0] RawSwitchs,
    output logic        Enter,
    output logic        Clear,
    output logic [11:0] Switchs
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             enter_ev, clear_ev;
    logic [11:0]      sw_meta, sw_sync, sw_prev;
    logic [CNT_W-1:0] scnt;
    logic             stable, pending, fire;

    input_conditioner_button #(
        .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
        .CNT_W            (CNT_W),
        .BUTTON_ACTIVE_LOW(BUTTON_ACTIVE_LOW)
    ) u_enter (
        .clock  (clock),
        .reset_n(reset_n),
        .key    (KeyEnter),
        .press  (enter_ev)
    );

    input_conditioner_button #(
        .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
        .CNT_W            (CNT_W),
        .BUTTON_ACTIVE_LOW(BUTTON_ACTIVE_LOW)
    ) u_clear (
        .clock  (clock),
        .reset_n(reset_n),
        .key    (KeyClear),
        .press  (clear_ev)
    );

    // Enter waits until the latched bus matches a settled input
    assign stable = (scnt == LAST) && (Switchs == sw_sync);
    assign fire   = (pending || enter_ev) && stable && !clear_ev;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sw_meta <= '0;
            sw_sync <= '0;
            sw_prev <= '0;
            scnt    <= '0;
            Switchs <= '0;
        end else begin
            sw_meta <= RawSwitchs;
            sw_sync <= sw_meta;
            sw_prev <= sw_sync;
            if (sw_sync != sw_prev) begin
                scnt <= '0;
            end else if (scnt != LAST) begin
                scnt <= scnt + CNT_W'(1);
            end else begin
                Switchs <= sw_sync;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 1'b0;
            Enter   <= 1'b0;
            Clear   <= 1'b0;
        end else begin
            Clear   <= clear_ev;
            Enter   <= fire;
            pending <= (pending || enter_ev) && !fire && !clear_ev;
        end
    end
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed and randomized checks of input_conditioner
// against a window-based behavioural model.
module tb_input_conditioner;
    localparam int D = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        KeyEnter = 1'b1;
    logic        KeyClear = 1'b1;
    logic [11:0] RawSwitchs = '0;
    logic        Enter, Clear;
    logic [11:0] Switchs;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit started = 0;

    input_conditioner #(
        .DEBOUNCE_CYCLES  (D),
        .CNT_W            (3),
        .BUTTON_ACTIVE_LOW(1'b1)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .KeyEnter  (KeyEnter),
        .KeyClear  (KeyClear),
        .RawSwitchs(RawSwitchs),
        .Enter     (Enter),
        .Clear     (Clear),
        .Switchs   (Switchs)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    // Model: a level is accepted after D+1 consecutive equal samples
    bit [1:0]    bq [2];
    bit [D:0]    win [2];
    int          nv [2];
    bit          db [2];
    logic [11:0] sp0, sp1, msw;
    logic [11:0] sh[$];
    bit          pend, expE, expC;

    function automatic bit btn_step(int b, bit e);
        bit ev = 1'b0;
        win[b] = {win[b][D-1:0], e};
        if (nv[b] < D + 1) nv[b]++;
        if (nv[b] == D + 1 && win[b] == {(D+1){~db[b]}}) begin
            db[b] = ~db[b];
            nv[b] = 0;
            ev = db[b];
        end
        return ev;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            bq[b] = '0; win[b] = '0; nv[b] = 0; db[b] = 1'b0;
        end
        sp0 = '0; sp1 = '0; msw = '0;
        sh.delete();
        sh.push_back(12'h000);
        pend = 1'b0; expE = 1'b0; expC = 1'b0;
    endtask

    always @(posedge clock or negedge reset_n) begin
        bit eE, eC, evE, evC, st, ld;
        logic [11:0] s;
        if (!reset_n) begin
            model_reset();
        end else begin
            eE = bq[0][1]; bq[0] = {bq[0][0], ~KeyEnter};
            eC = bq[1][1]; bq[1] = {bq[1][0], ~KeyClear};
            evE = btn_step(0, eE);
            evC = btn_step(1, eC);
            s = sp1; sp1 = sp0; sp0 = RawSwitchs;
            st = 1'b0;
            if (sh.size() >= D) begin
                st = 1'b1;
                for (int i = 0; i < D; i++)
                    if (sh[sh.size()-1-i] != sh[sh.size()-1]) st = 1'b0;
            end
            st = st && (msw == s);
            sh.push_back(s);
            if (sh.size() > D + 1) void'(sh.pop_front());
            ld = (sh.size() == D + 1);
            foreach (sh[i]) if (sh[i] != s) ld = 1'b0;
            if (ld) msw = s;
            expC = evC;
            if (evC) begin
                expE = 1'b0; pend = 1'b0;
            end else if ((pend || evE) && st) begin
                expE = 1'b1; pend = 1'b0;
            end else begin
                expE = 1'b0; pend = pend || evE;
            end
        end
    end

    always @(negedge clock) begin
        if (started) begin
            total++;
            if (Enter !== expE || Clear !== expC || Switchs !== msw) begin
                bad++;
                $display("FAIL model cyc=%0d Enter=%b/%b Clear=%b/%b Switchs=%h/%h",
                         cyc, Enter, expE, Clear, expC, Switchs, msw);
            end
        end
    end

    // Pulse and switch-change bookkeeping for the directed checks
    int ec = 0, cc = 0, elast = -1, clast = -1, swchg = -1;
    logic [11:0] swprev = '0;
    always @(negedge clock) begin
        if (Enter) begin ec++; elast = cyc; end
        if (Clear) begin cc++; clast = cyc; end
        if (Switchs !== swprev) begin swchg = cyc; swprev = Switchs; end
    end

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic clr_counts();
        ec = 0; cc = 0; elast = -1; clast = -1;
    endtask

    int t0, r0;

    initial begin
        reset_n = 1'b0;
        KeyEnter = 1'($urandom); KeyClear = 1'($urandom);
        RawSwitchs = 12'($urandom);
        tick(1);
        started = 1;
        tick(3);
        @(negedge clock);
        chk("rst_enter", int'(Enter), 0);
        chk("rst_clear", int'(Clear), 0);
        chk("rst_switchs", int'(Switchs), 0);
        tick(1);
        KeyEnter = 1'b1; KeyClear = 1'b1; RawSwitchs = '0;
        tick(2);
        reset_n = 1'b1;
        clr_counts();
        tick(12);
        chk("rst_quiet", ec + cc, 0);

        clr_counts();
        KeyEnter = 1'b0; t0 = cyc + 1;
        tick(20);
        KeyEnter = 1'b1;
        tick(15);
        chk("press_cnt", ec, 1);
        chk("press_lat", elast - t0, 6);

        clr_counts();
        for (int i = 0; i < 10; i++) begin
            KeyClear = 1'(i % 2);
            tick(2);
        end
        chk("bounce_quiet", cc, 0);
        KeyClear = 1'b0; t0 = cyc + 1;
        tick(15);
        KeyClear = 1'b1;
        tick(15);
        chk("bounce_cnt", cc, 1);
        chk("bounce_lat", clast - t0, 6);

        clr_counts();
        swchg = -1;
        RawSwitchs = 12'h2A5; t0 = cyc + 1;
        tick(1);
        KeyEnter = 1'b0;
        tick(20);
        KeyEnter = 1'b1;
        tick(15);
        chk("sw_lat", swchg - t0, 6);
        chk("sw_val", int'(Switchs), 'h2A5);
        chk("sw_enter_cnt", ec, 1);
        chk("sw_enter_lat", elast - t0, 7);

        clr_counts();
        swchg = -1;
        RawSwitchs = 12'h15C; KeyEnter = 1'b0; t0 = cyc + 1;
        tick(20);
        KeyEnter = 1'b1;
        tick(15);
        chk("defer_sw_lat", swchg - t0, 6);
        chk("defer_enter_cnt", ec, 1);
        chk("defer_enter_lat", elast - t0, 7);

        clr_counts();
        KeyEnter = 1'b0; KeyClear = 1'b0; t0 = cyc + 1;
        tick(15);
        KeyEnter = 1'b1; KeyClear = 1'b1;
        tick(15);
        chk("simul_clear_cnt", cc, 1);
        chk("simul_clear_lat", clast - t0, 6);
        chk("simul_enter_cnt", ec, 0);

        RawSwitchs = '0;
        tick(15);
        clr_counts();
        KeyEnter = 1'b0; t0 = cyc + 1;
        tick(3);
        reset_n = 1'b0;
        chk("midrst_before", ec, 0);
        tick(1);
        reset_n = 1'b1; r0 = cyc + 1;
        tick(15);
        chk("midrst_cnt", ec, 1);
        chk("midrst_lat", elast - r0, 6);
        KeyEnter = 1'b1;
        tick(15);

        for (int n = 0; n < 350; n++) begin
            if ($urandom_range(0, 2) == 0) KeyEnter = ~KeyEnter;
            if ($urandom_range(0, 2) == 0) KeyClear = ~KeyClear;
            if ($urandom_range(0, 3) == 0) RawSwitchs = 12'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                reset_n = 1'b0;
                tick(1);
                reset_n = 1'b1;
            end
            tick($urandom_range(1, 9));
        end
        KeyEnter = 1'b1; KeyClear = 1'b1;
        tick(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
